cic_comp_fir: RTL and testbench
===============================

// Module: cic_comp_fir
// PURPOSE
// - Droop-compensation FIR. Sits directly downstream of the CIC decimator and consumes its decimated output.
// - Symmetric odd-length FIR, computed serially: one multiply-accumulate per cycle with a symmetric pre-add.
// - Sample rate is low, so one multiplier serves all taps.
// - Valid/ready handshake on both sides. Output goes to the next stage, e.g. a half-band filter or the sample FIFO.
// PARAMETERS
// - DW     16  input/output sample width, signed two's complement
// - NTAPS  15  tap count; must be odd and >= 3; elaboration $error otherwise
// - CW     16  coefficient width, signed Q1.(CW-1)
// PORTS
// - clk        in   1   single clock; all logic rises on posedge clk
// - reset_n    in   1   synchronous, active-low reset, sampled on posedge clk
// - bypass     in   1   1 = pass the sample through unfiltered; sampled only on accept
// - in_valid   in   1   in_data is valid
// - in_ready   out  1   block can accept a sample (state IDLE)
// - in_data    in   DW  signed input sample, taken from the CIC output
// - out_valid  out  1   out_data is valid; held until out_ready
// - out_ready  in   1   downstream accepts out_data
// - out_data   out  DW  signed filtered sample
// BEHAVIOUR
// - Reset (reset_n==0 at posedge) has priority over everything, including reset mid-MAC or mid-HOLD:
//   state=IDLE, delay line x[0..NTAPS-1]=0, acc=0, tap index k=0, out_valid=0, out_data=0, in_ready=1 after reset.
// - Accept occurs when in_valid && in_ready.
//   - Shift the delay line: x[0]<=in_data, x[i]<=x[i-1]. Latch bypass into byp_q.
//   - If byp_q: next state HOLD, out_data<=in_data. The delay line is still updated.
//   - Else: next state MAC, acc<=0, k<=0.
// - FSM states: IDLE -> MAC -> HOLD -> IDLE.
//   - IDLE: in_ready=1, out_valid=0.
//   - MAC: runs M=(NTAPS+1)/2 cycles, k=0..M-1.
//     - k<M-1: acc += COEF[k]*(x[k]+x[NTAPS-1-k]). The pre-add is DW+1 bits and must not wrap.
//     - k==M-1 (centre tap): acc += COEF[M-1]*x[M-1].
//     - After the last term: out_data<=sat(round(acc)), go to HOLD.
//   - HOLD: out_valid=1; out_data is stable until out_ready.
//     - out_valid && out_ready -> IDLE on the next edge.
//     - There is no same-cycle HOLD->accept; in_ready=0 in HOLD.
// - Accumulator width is ACCW = DW+1+CW+$clog2(M). No internal overflow is possible.
// - Rounding is round-half-up: r = (acc + 2^(CW-2)) >>> (CW-1).
// - Saturation: r > 2^(DW-1)-1 -> 0x7FFF (for DW=16); r < -2^(DW-1) -> 0x8000. Otherwise truncate to DW bits.
// - Latency, accept edge to out_valid high:
//   - filtered path: M+1 cycles (9 at default);
//   - bypass: 1 cycle.
// - Throughput: one sample per M+2 cycles, plus however long out_ready is held low. The upstream decimation ratio must leave that margin.
// - Changing bypass while in MAC/HOLD has no effect on the sample in flight.
// - in_valid while in_ready=0: the sample is not taken. Upstream must hold it; nothing is dropped silently.
// STRUCTURE
// - Package cic_pkg holds:
//   - localparam COMP_NTAPS, COMP_CW;
//   - localparam logic signed [COMP_CW-1:0] COMP_COEF[COMP_NTAPS/2+1], half of the symmetric set, centre tap last;
//   - typedef enum logic [1:0] {ST_IDLE, ST_MAC, ST_HOLD} comp_state_t;
//   - function sat_round(acc) shared with future decimation stages.
// - Sub-module comp_mac: pre-adder, multiplier and accumulator.
//   - Inputs: clr, en, xa, xb, coef, centre.
//   - Output: acc.
//   - Purely registered.
// - The top level holds the FSM, the delay line, the tap index and the output register.
// TESTING
// - Impulse: in_data=16384 (0.5) followed by 14 zeros, out_ready=1.
//   Output n = round(COEF[n]*0.5) mirrored; out_valid exactly 9 cycles after each accept.
// - DC: 15 samples of 8192.
//   The 15th output = sat_round(8192*sum(all COEF)); it matches the golden model bit-exactly.
// - Saturation: feed 0x7FFF continuously with coefficient gain >1.
//   out_data=0x7FFF, never wraps negative. Repeat with 0x8000: output 0x8000.
// - Backpressure: hold out_ready=0 for 20 cycles in HOLD.
//   out_data stable, out_valid=1, in_ready=0, the in_valid sample is not consumed.
//   Release: one transfer, then IDLE.
// - Bypass: bypass=1, in_data=0x1234.
//   out_data=0x1234 with out_valid 1 cycle after accept. The next filtered output still includes 0x1234 in its history.
// - Reset mid-MAC: reset_n=0 for 1 cycle at k=4.
//   Next cycle: in_ready=1, out_valid=0. The next impulse response matches the clean impulse test, with no residue.

Source files
------------

// File: rtl/cic_pkg.sv
// Shared definitions for the CIC decimation chain: compensation FIR taps,
// its FSM state type and the rounding/saturation helper.
package cic_pkg;

    localparam int COMP_NTAPS = 15;
    localparam int COMP_CW    = 16;

    // Half of the symmetric Q1.15 tap set, centre tap last; DC gain ~1.25.
    localparam logic signed [COMP_CW-1:0] COMP_COEF [COMP_NTAPS/2+1] = '{
        -16'sd200, 16'sd300, -16'sd600, 16'sd1200,
        -16'sd2200, 16'sd4000, 16'sd6000, 16'sd24000
    };

    typedef enum logic [1:0] {ST_IDLE, ST_MAC, ST_HOLD} comp_state_t;

    // Round-half-up by 2^(cw-1), then clamp to a signed dw-bit range.
    function automatic logic signed [63:0] sat_round(input logic signed [63:0] acc,
                                                     input int dw, input int cw);
        logic signed [63:0] r, hi, lo;
        r  = (acc + (64'sd1 <<< (cw - 2))) >>> (cw - 1);
        hi = (64'sd1 <<< (dw - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (dw - 1));
        if (r > hi)
            r = hi;
        else if (r < lo)
            r = lo;
        return r;
    endfunction

endpackage

// File: rtl/cic_comp_fir_mac.sv
// Symmetric pre-add, single multiplier and accumulator for the serial
// compensation FIR.
module comp_mac #(
    parameter int DW   = 16,
    parameter int CW   = 16,
    parameter int ACCW = 36
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   clr,
    input  logic                   en,
    input  logic signed [DW-1:0]   xa,
    input  logic signed [DW-1:0]   xb,
    input  logic signed [CW-1:0]   coef,
    input  logic                   centre,
    output logic signed [ACCW-1:0] acc
);

    logic signed [DW:0]    pre;
    logic signed [DW+CW:0] prod;

    // One extra bit so the pre-add of two full-scale samples cannot wrap.
    always_comb begin
        pre = (DW+1)'(xa);
        if (!centre)
            pre = pre + (DW+1)'(xb);
    end

    assign prod = (DW+CW+1)'(pre) * (DW+CW+1)'(coef);

    always_ff @(posedge clk) begin
        if (!reset_n)
            acc <= '0;
        else if (clr)
            acc <= '0;
        else if (en)
            acc <= acc + ACCW'(prod);
    end

endmodule

// File: rtl/cic_comp_fir.sv
// CIC droop-compensation FIR: symmetric odd-length taps, one MAC per cycle,
// valid/ready on both sides, optional bypass.
module cic_comp_fir
    import cic_pkg::*;
#(
    parameter int DW    = 16,
    parameter int NTAPS = COMP_NTAPS,
    parameter int CW    = COMP_CW
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 bypass,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic signed [DW-1:0] in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic signed [DW-1:0] out_data
);

    localparam int M    = (NTAPS + 1) / 2;
    localparam int ACCW = DW + 1 + CW + $clog2(M);
    localparam int KW   = $clog2(M);
    localparam int XW   = $clog2(NTAPS);
    localparam logic [KW-1:0] KLAST = KW'(M - 1);

    if ((NTAPS % 2) == 0 || NTAPS < 3) begin : g_bad_ntaps
        $error("cic_comp_fir: NTAPS must be odd and >= 3");
    end
    if (NTAPS != COMP_NTAPS || CW != COMP_CW) begin : g_bad_coef
        $error("cic_comp_fir: NTAPS/CW must match the cic_pkg coefficient set");
    end

    comp_state_t            state, state_nxt;
    logic signed [DW-1:0]   x [NTAPS];
    logic [KW-1:0]          k;
    logic                   byp_q;
    logic signed [DW-1:0]   byp_data;
    logic signed [ACCW-1:0] acc;
    logic                   accept, last;
    logic [XW-1:0]          ia, ib;

    assign in_ready  = (state == ST_IDLE);
    assign out_valid = (state == ST_HOLD);
    assign accept    = in_valid && in_ready;
    assign last      = (state == ST_MAC) && (k == KLAST);
    assign ia        = XW'(k);
    assign ib        = XW'(NTAPS - 1) - XW'(k);

    always_ff @(posedge clk) begin
        if (!reset_n)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE: if (in_valid) state_nxt = bypass ? ST_HOLD : ST_MAC;
            ST_MAC:  if (k == KLAST) state_nxt = ST_HOLD;
            ST_HOLD: if (out_ready) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Delay line advances on every accept, bypassed samples included.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < NTAPS; i++)
                x[i] <= '0;
            k        <= '0;
            byp_q    <= 1'b0;
            byp_data <= '0;
        end else if (accept) begin
            x[0] <= in_data;
            for (int i = 1; i < NTAPS; i++)
                x[i] <= x[i-1];
            k        <= '0;
            byp_q    <= bypass;
            byp_data <= in_data;
        end else if (state == ST_MAC && !last) begin
            k <= k + 1'b1;
        end
    end

    comp_mac #(.DW(DW), .CW(CW), .ACCW(ACCW)) u_mac (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (accept),
        .en      (state == ST_MAC),
        .xa      (x[ia]),
        .xb      (x[ib]),
        .coef    (COMP_COEF[k]),
        .centre  (last),
        .acc     (acc)
    );

    // acc is frozen outside MAC, so the rounded result is stable through HOLD
    // and reads as zero straight after reset.
    assign out_data = byp_q ? byp_data : DW'(sat_round(64'(acc), DW, CW));

endmodule

// File: tb/tb_cic_comp_fir.sv
// Directed bench for cic_comp_fir with a direct-form golden model and an
// expected-value queue.
module tb_cic_comp_fir;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        bypass = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b1;
    logic [15:0] in_data = '0;
    logic        in_ready, out_valid;
    logic [15:0] out_data;

    int ncmp = 0;
    int nfail = 0;
    logic [15:0] exp_q[$];
    int hist[15];
    localparam int H[15] = '{-200, 300, -600, 1200, -2200, 4000, 6000, 24000,
                             6000, 4000, -2200, 1200, -600, 300, -200};

    cic_comp_fir dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .bypass    (bypass),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        ncmp++;
        assert (obs === expv) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    function automatic logic [15:0] model(input logic [15:0] d, input logic byp);
        longint a, r;
        for (int i = 14; i > 0; i--)
            hist[i] = hist[i-1];
        hist[0] = $signed(d);
        if (byp)
            return d;
        a = 0;
        for (int i = 0; i < 15; i++)
            a += longint'(H[i]) * longint'(hist[i]);
        r = (a + 16384) >>> 15;
        if (r > 32767)
            r = 32767;
        else if (r < -32768)
            r = -32768;
        return r[15:0];
    endfunction

    task automatic send(input logic [15:0] d, input logic byp, input int lat, input string tag);
        int n;
        in_data = d; bypass = byp; in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 40) begin @(negedge clk); n++; end
        chk({tag, "/rdy"}, 32'(in_ready), 32'd1);
        @(posedge clk);
        exp_q.push_back(model(d, byp));
        @(negedge clk);
        in_valid = 1'b0; bypass = !byp; in_data = 16'hDEAD;
        n = 1;
        while (!out_valid && n < 40) begin @(negedge clk); n++; end
        chk({tag, "/lat"}, 32'(n), 32'(lat));
    endtask

    task automatic collect(input string tag);
        logic [15:0] e;
        e = 16'hxxxx;
        if (exp_q.size() != 0)
            e = exp_q.pop_front();
        chk({tag, "/ov"}, 32'(out_valid), 32'd1);
        chk({tag, "/data"}, 32'(out_data), 32'(e));
        @(negedge clk);
    endtask

    task automatic xfer(input logic [15:0] d, input logic byp, input int lat, input string tag);
        send(d, byp, lat, tag);
        collect(tag);
    endtask

    initial begin
        for (int i = 0; i < 15; i++) hist[i] = 0;
        repeat (3) @(negedge clk);
        chk("rst/in_ready", 32'(in_ready), 32'd1);
        chk("rst/out_valid", 32'(out_valid), 32'd0);
        chk("rst/out_data", 32'(out_data), 32'd0);
        reset_n = 1'b1;
        @(negedge clk);

        // impulse of 0.5 walks through every tap
        xfer(16'h4000, 1'b0, 9, "imp0");
        for (int i = 1; i < 15; i++) xfer(16'h0000, 1'b0, 9, $sformatf("imp%0d", i));

        for (int i = 0; i < 15; i++) xfer(16'd8192, 1'b0, 9, $sformatf("dc%0d", i));
        for (int i = 0; i < 15; i++) xfer(16'h7FFF, 1'b0, 9, $sformatf("satp%0d", i));
        for (int i = 0; i < 15; i++) xfer(16'h8000, 1'b0, 9, $sformatf("satn%0d", i));

        xfer(16'h1234, 1'b1, 1, "byp");
        xfer(16'h0100, 1'b0, 9, "byp_next");

        // backpressure: output held, a pending input must not be taken
        out_ready = 1'b0;
        send(16'h0800, 1'b0, 9, "bp");
        in_valid = 1'b1; in_data = 16'h7777;
        for (int i = 0; i < 20; i++) begin
            chk("bp/hold_ov", 32'(out_valid), 32'd1);
            chk("bp/hold_rdy", 32'(in_ready), 32'd0);
            chk("bp/hold_data", 32'(out_data), 32'(exp_q[0]));
            @(negedge clk);
        end
        out_ready = 1'b1;
        collect("bp");
        chk("bp/idle_rdy", 32'(in_ready), 32'd1);
        chk("bp/idle_ov", 32'(out_valid), 32'd0);
        in_valid = 1'b0;
        xfer(16'h0000, 1'b0, 9, "bp_after");

        // reset pulse while the MAC is at tap 4
        in_data = 16'h4000; bypass = 1'b0; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (4) @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        chk("rmac/in_ready", 32'(in_ready), 32'd1);
        chk("rmac/out_valid", 32'(out_valid), 32'd0);
        for (int i = 0; i < 15; i++) hist[i] = 0;
        exp_q.delete();
        xfer(16'h4000, 1'b0, 9, "rimp0");
        for (int i = 1; i < 15; i++) xfer(16'h0000, 1'b0, 9, $sformatf("rimp%0d", i));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
